// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU phase sequencer.
// Provides the sequencer state enum, the default counter width, the one-hot
// phase encoding and small decode helpers used by cpu_sequencer.
// Optional feature macro: SEQ_STEP_EN (adds the PAUSE state).
package cpu_seq_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned PH_W      = 3;

    // One-hot phase vector, bit order {EXEC2, EXEC1, FETCH}
    localparam logic [PH_W-1:0] PH_NONE  = 3'b000;
    localparam logic [PH_W-1:0] PH_FETCH = 3'b001;
    localparam logic [PH_W-1:0] PH_EXEC1 = 3'b010;
    localparam logic [PH_W-1:0] PH_EXEC2 = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_HALT  = 3'd4
`ifdef SEQ_STEP_EN
        ,
        ST_PAUSE = 3'd5
`endif
    } seq_state_t;

    // Phase strobes that are high while the sequencer sits in state s
    function automatic logic [PH_W-1:0] phase_of(seq_state_t s);
        case (s)
            ST_FETCH: return PH_FETCH;
            ST_EXEC1: return PH_EXEC1;
            ST_EXEC2: return PH_EXEC2;
            default:  return PH_NONE;
        endcase
    endfunction

    // States that contribute to the active-cycle counter
    function automatic logic is_active(seq_state_t s);
        case (s)
            ST_FETCH, ST_EXEC1, ST_EXEC2: return 1'b1;
`ifdef SEQ_STEP_EN
            ST_PAUSE:                     return 1'b1;
`endif
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_counter.sv
// seq_counter: CNT_W-wide wrapping performance counter.
// Ports:
//   clk   - clock
//   clr   - synchronous clear, wins over en
//   en    - increment by one this cycle
//   count - current value, wraps from all-ones to zero
module seq_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Clear takes priority over a coincident increment
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: phase sequencer for the single-cycle-decode CPU.
// Generates one-hot FETCH/EXEC1/EXEC2 strobes, handles decoder EXEC2
// requests and STP halts, applies wait-states and keeps retired-instruction
// and active-cycle counters.
// Optional feature macro: SEQ_STEP_EN (single-step ports and PAUSE state).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - leaves IDLE or HALT
//   E2, stp           - decoder requests, sampled only in EXEC1
//   wait_req          - stalls FETCH/EXEC1/EXEC2
//   clr_cnt           - synchronous clear of both counters
//   step_mode/step_req- (SEQ_STEP_EN only) pause after each instruction
//   FETCH/EXEC1/EXEC2 - registered phase strobes
//   halted            - high in HALT
//   instr_count       - retired instructions
//   cycle_count       - cycles in FETCH/EXEC1/EXEC2/PAUSE
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             E2,
    input  logic             stp,
    input  logic             wait_req,
    input  logic             clr_cnt,
`ifdef SEQ_STEP_EN
    input  logic             step_mode,
    input  logic             step_req,
`endif
    output logic             FETCH,
    output logic             EXEC1,
    output logic             EXEC2,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    seq_state_t        retire_dest;
    logic              retire;
    logic [PH_W-1:0]   phase_q;
    logic              cnt_clr;

    // Where a normal (non-STP) retirement goes
`ifdef SEQ_STEP_EN
    assign retire_dest = step_mode ? ST_PAUSE : ST_FETCH;
`else
    assign retire_dest = ST_FETCH;
`endif

    // Next-state decision and retirement detection
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (AUTO_START || start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!wait_req) begin
                    state_nxt = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                if (!wait_req) begin
                    if (stp) begin
                        state_nxt = ST_HALT;
                        retire    = 1'b1;
                    end else if (E2) begin
                        state_nxt = ST_EXEC2;
                    end else begin
                        state_nxt = retire_dest;
                        retire    = 1'b1;
                    end
                end
            end
            ST_EXEC2: begin
                if (!wait_req) begin
                    state_nxt = retire_dest;
                    retire    = 1'b1;
                end
            end
            ST_HALT: begin
                // R0 is not advanced by STP, so resuming re-fetches it
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
`ifdef SEQ_STEP_EN
            ST_PAUSE: begin
                if (step_req || !step_mode) begin
                    state_nxt = ST_FETCH;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; outputs registered from the next state so they
    // always equal the decode of the current state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase_q <= PH_NONE;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase_q <= phase_of(state_nxt);
            halted  <= (state_nxt == ST_HALT);
        end
    end

    assign FETCH = phase_q[0];
    assign EXEC1 = phase_q[1];
    assign EXEC2 = phase_q[2];

    // Reset shares the clear path so an aborted instruction is never counted
    assign cnt_clr = rst | clr_cnt;

    seq_counter #(
        .CNT_W (CNT_W)
    ) u_instr_cnt (
        .clk   (clk),
        .clr   (cnt_clr),
        .en    (retire),
        .count (instr_count)
    );

    seq_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .clr   (cnt_clr),
        .en    (is_active(state)),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned SW = 3;
`ifdef SEQ_STEP_EN
    localparam bit STEP_BUILT = 1'b1;
`else
    localparam bit STEP_BUILT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT: AUTO_START=1, 16-bit counters
    logic rst = 1'b1, start = 1'b0, e2 = 1'b0, stp = 1'b0;
    logic wait_req = 1'b0, clr_cnt = 1'b0;
    logic step_mode = 1'b0, step_req = 1'b0;
    logic fetch, exec1, exec2, halted;
    logic [W-1:0] instr_count, cycle_count;

    // small DUT: AUTO_START=0, 3-bit counters for wrap checks
    logic s_rst = 1'b1, s_start = 1'b0;
    logic s_fetch, s_exec1, s_exec2, s_halted;
    logic [SW-1:0] s_instr, s_cycle;

    cpu_sequencer #(.CNT_W(W), .AUTO_START(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .E2(e2), .stp(stp),
        .wait_req(wait_req), .clr_cnt(clr_cnt),
`ifdef SEQ_STEP_EN
        .step_mode(step_mode), .step_req(step_req),
`endif
        .FETCH(fetch), .EXEC1(exec1), .EXEC2(exec2), .halted(halted),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    cpu_sequencer #(.CNT_W(SW), .AUTO_START(1'b0)) dut_s (
        .clk(clk), .rst(s_rst), .start(s_start), .E2(1'b0), .stp(1'b0),
        .wait_req(1'b0), .clr_cnt(1'b0),
`ifdef SEQ_STEP_EN
        .step_mode(1'b0), .step_req(1'b0),
`endif
        .FETCH(s_fetch), .EXEC1(s_exec1), .EXEC2(s_exec2), .halted(s_halted),
        .instr_count(s_instr), .cycle_count(s_cycle)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural reference for the main DUT
    typedef enum int {M_IDLE, M_F, M_E1, M_E2, M_HALT, M_PAUSE} mph_t;
    mph_t        m_ph    = M_IDLE;
    int unsigned m_instr = 0;
    int unsigned m_cycle = 0;

    // Advance one clock; reference model follows the rules on the inputs
    // that are stable across the edge
    task automatic tick();
        mph_t        n;
        bit          ret;
        bit          stepping;
        int unsigned ni, nc;
        stepping = STEP_BUILT && step_mode;
        n   = m_ph;
        ret = 1'b0;
        case (m_ph)
            M_IDLE:  n = M_F;
            M_F:     if (!wait_req) n = M_E1;
            M_E1:    if (!wait_req) begin
                         if (stp) begin n = M_HALT; ret = 1'b1; end
                         else if (e2) n = M_E2;
                         else begin n = stepping ? M_PAUSE : M_F; ret = 1'b1; end
                     end
            M_E2:    if (!wait_req) begin n = stepping ? M_PAUSE : M_F; ret = 1'b1; end
            M_HALT:  if (start) n = M_F;
            M_PAUSE: if (!step_mode || step_req) n = M_F;
            default: n = M_IDLE;
        endcase
        nc = (m_ph inside {M_F, M_E1, M_E2, M_PAUSE}) ? (m_cycle + 1) % (1 << W) : m_cycle;
        ni = ret ? (m_instr + 1) % (1 << W) : m_instr;
        if (clr_cnt) begin ni = 0; nc = 0; end
        if (rst) begin n = M_IDLE; ni = 0; nc = 0; end
        @(posedge clk);
        #1;
        m_ph    = n;
        m_instr = ni;
        m_cycle = nc;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; e2 = 1'b0; stp = 1'b0;
        wait_req = 1'b0; clr_cnt = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({halted, exec2, exec1, fetch} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_phases got=%b exp=0000", {halted, exec2, exec1, fetch});
        end
        tests++;
        if (instr_count !== '0 || cycle_count !== '0) begin
            fails++;
            $display("FAIL reset_counts got instr=%0d cycle=%0d exp 0/0", instr_count, cycle_count);
        end
    endtask

    task automatic test_single_exec();
        logic [3:0] seq [7];
        seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            tests++;
            if ({halted, exec2, exec1, fetch} !== seq[i]) begin
                fails++;
                $display("FAIL single_seq[%0d] got=%b exp=%b", i, {halted, exec2, exec1, fetch}, seq[i]);
            end
        end
        tick();
        tests++;
        if (instr_count !== 16'd3 || cycle_count !== 16'd6) begin
            fails++;
            $display("FAIL single_counts got instr=%0d cycle=%0d exp 3/6", instr_count, cycle_count);
        end
    endtask

    task automatic test_exec2();
        logic [3:0] seq [9];
        seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0001};
        do_reset();
        for (int i = 1; i < 9; i++) begin
            e2 = (i == 5);
            tick();
            tests++;
            if ({halted, exec2, exec1, fetch} !== seq[i]) begin
                fails++;
                $display("FAIL e2_seq[%0d] got=%b exp=%b", i, {halted, exec2, exec1, fetch}, seq[i]);
            end
        end
        e2 = 1'b0;
        tests++;
        if (instr_count !== 16'd3 || cycle_count !== 16'd7) begin
            fails++;
            $display("FAIL e2_counts got instr=%0d cycle=%0d exp 3/7", instr_count, cycle_count);
        end
    endtask

    task automatic test_wait();
        do_reset();
        tick();
        tick();
        wait_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (exec1 !== 1'b1 || instr_count !== 16'd0) begin
                fails++;
                $display("FAIL wait_hold[%0d] got exec1=%b instr=%0d exp 1/0", i, exec1, instr_count);
            end
        end
        wait_req = 1'b0;
        tick();
        tests++;
        if (fetch !== 1'b1 || instr_count !== 16'd1 || cycle_count !== 16'd6) begin
            fails++;
            $display("FAIL wait_release got fetch=%b instr=%0d cycle=%0d exp 1/1/6",
                     fetch, instr_count, cycle_count);
        end
    endtask

    task automatic test_stp_halt();
        do_reset();
        tick();
        tick();
        stp = 1'b1; e2 = 1'b1;
        tick();
        stp = 1'b0; e2 = 1'b0;
        tests++;
        if (halted !== 1'b1 || exec2 !== 1'b0 || instr_count !== 16'd1 || cycle_count !== 16'd2) begin
            fails++;
            $display("FAIL stp_enter got halted=%b exec2=%b instr=%0d cycle=%0d exp 1/0/1/2",
                     halted, exec2, instr_count, cycle_count);
        end
        wait_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        wait_req = 1'b0;
        tests++;
        if (halted !== 1'b1 || cycle_count !== 16'd2) begin
            fails++;
            $display("FAIL stp_hold got halted=%b cycle=%0d exp 1/2", halted, cycle_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (fetch !== 1'b1 || halted !== 1'b0 || cycle_count !== 16'd2) begin
            fails++;
            $display("FAIL stp_resume got fetch=%b halted=%b cycle=%0d exp 1/0/2", fetch, halted, cycle_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (exec1 !== 1'b1 || cycle_count !== 16'd3) begin
            fails++;
            $display("FAIL start_ignored got exec1=%b cycle=%0d exp 1/3", exec1, cycle_count);
        end
    endtask

    task automatic test_clr_coincide();
        do_reset();
        tick();
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        tests++;
        if (fetch !== 1'b1 || instr_count !== 16'd0 || cycle_count !== 16'd0) begin
            fails++;
            $display("FAIL clr_coincide got fetch=%b instr=%0d cycle=%0d exp 1/0/0", fetch, instr_count, cycle_count);
        end
        tick();
        tick();
        tests++;
        if (instr_count !== 16'd1 || cycle_count !== 16'd2) begin
            fails++;
            $display("FAIL clr_after got instr=%0d cycle=%0d exp 1/2", instr_count, cycle_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(); tick(); tick(); tick();
        e2 = 1'b1;
        tick();
        e2 = 1'b0;
        rst = 1'b1;
        tick();
        tests++;
        if ({halted, exec2, exec1, fetch} !== 4'b0000 || instr_count !== '0 || cycle_count !== '0) begin
            fails++;
            $display("FAIL reset_mid got ph=%b instr=%0d cycle=%0d exp 0000/0/0",
                     {halted, exec2, exec1, fetch}, instr_count, cycle_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_small();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (s_fetch !== 1'b0 || s_exec1 !== 1'b0 || s_halted !== 1'b0) begin
            fails++;
            $display("FAIL manual_idle got fetch=%b exec1=%b halted=%b exp 0/0/0", s_fetch, s_exec1, s_halted);
        end
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tests++;
        if (s_fetch !== 1'b1) begin
            fails++;
            $display("FAIL manual_start got fetch=%b exp 1", s_fetch);
        end
        for (int i = 0; i < 14; i++) tick();
        tests++;
        if (s_instr !== 3'd7 || s_cycle !== 3'd6) begin
            fails++;
            $display("FAIL wrap_near got instr=%0d cycle=%0d exp 7/6", s_instr, s_cycle);
        end
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (s_instr !== 3'd1 || s_cycle !== 3'd2 || s_exec2 !== 1'b0) begin
            fails++;
            $display("FAIL wrap_over got instr=%0d cycle=%0d exp 1/2", s_instr, s_cycle);
        end
        s_rst = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] exp_ph;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            wait_req = ($urandom % 4) == 0;
            e2       = 1'($urandom);
            stp      = ($urandom % 12) == 0;
            start    = ($urandom % 6) == 0;
            clr_cnt  = ($urandom % 60) == 0;
            rst      = ($urandom % 150) == 0;
            step_req = ($urandom % 4) == 0;
            if (STEP_BUILT && ($urandom % 10) == 0) step_mode = ~step_mode;
            tick();
            exp_ph = {m_ph == M_HALT, m_ph == M_E2, m_ph == M_E1, m_ph == M_F};
            tests++;
            if ({halted, exec2, exec1, fetch} !== exp_ph ||
                instr_count !== W'(m_instr) || cycle_count !== W'(m_cycle)) begin
                fails++;
                $display("FAIL random[%0d] got ph=%b instr=%0d cycle=%0d exp ph=%b instr=%0d cycle=%0d",
                         i, {halted, exec2, exec1, fetch}, instr_count, cycle_count,
                         exp_ph, m_instr, m_cycle);
            end
        end
        do_reset();
    endtask

`ifdef SEQ_STEP_EN
    task automatic test_step();
        do_reset();
        step_mode = 1'b1;
        tick(); tick(); tick();
        tick(); tick();
        tests++;
        if ({halted, exec2, exec1, fetch} !== 4'b0000 || instr_count !== 16'd1 || cycle_count !== 16'd4) begin
            fails++;
            $display("FAIL step_pause got ph=%b instr=%0d cycle=%0d exp 0000/1/4",
                     {halted, exec2, exec1, fetch}, instr_count, cycle_count);
        end
        for (int k = 0; k < 2; k++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            tests++;
            if (fetch !== 1'b1) begin
                fails++;
                $display("FAIL step_go[%0d] got fetch=%b exp 1", k, fetch);
            end
            tick(); tick(); tick();
        end
        tests++;
        if (instr_count !== 16'd3 || fetch !== 1'b0 || exec1 !== 1'b0) begin
            fails++;
            $display("FAIL step_count got instr=%0d fetch=%b exec1=%b exp 3/0/0", instr_count, fetch, exec1);
        end
        step_mode = 1'b0;
        tick();
        tests++;
        if (fetch !== 1'b1) begin
            fails++;
            $display("FAIL step_leave got fetch=%b exp 1", fetch);
        end
        step_mode = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({halted, exec2, exec1, fetch} !== 4'b0000 || instr_count !== '0 || cycle_count !== '0) begin
            fails++;
            $display("FAIL step_reset got ph=%b instr=%0d cycle=%0d exp 0000/0/0",
                     {halted, exec2, exec1, fetch}, instr_count, cycle_count);
        end
        step_mode = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_exec();
        test_exec2();
        test_wait();
        test_stp_halt();
        test_clr_coincide();
        test_reset_mid();
        test_wrap_small();
`ifdef SEQ_STEP_EN
        test_step();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Phase sequencer for the single-cycle-decode CPU. It generates the one-hot FETCH / EXEC1 / EXEC2 phase strobes consumed by the instruction decoder and honours two inputs from the decoder: the two-cycle request (E2) and the decoded STP instruction. It also applies external wait-states and keeps retired-instruction and active-cycle counters. It sits between the top-level clock/reset and the decoder.

## Interface
- CNT_W, 16, width of both performance counters
- AUTO_START, 1, 1 = leave IDLE automatically after reset; 0 = wait for `start`

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE or HALT
- E2  in  1  decoder request for an EXEC2 cycle; sampled only in EXEC1
- stp  in  1  current instruction is STP; sampled only in EXEC1
- wait_req  in  1  stall; holds FETCH/EXEC1/EXEC2 in place while high
- clr_cnt  in  1  synchronous clear of both counters
- FETCH  out  1  fetch phase strobe
- EXEC1  out  1  first execute phase strobe
- EXEC2  out  1  second execute phase strobe
- halted  out  1  high in HALT
- instr_count  out  CNT_W  retired instructions, wraps
- cycle_count  out  CNT_W  cycles spent in FETCH/EXEC1/EXEC2/PAUSE, wraps

## Operation
- States: IDLE, FETCH, EXEC1, EXEC2, HALT (+ PAUSE when stepping is compiled in).
- Reset: state IDLE; FETCH=EXEC1=EXEC2=halted=0; both counters 0.
- IDLE -> FETCH when AUTO_START=1 or `start`=1; otherwise stay.
- FETCH: wait_req ? stay : EXEC1.
- EXEC1: wait_req ? stay : stp ? HALT : E2 ? EXEC2 : FETCH.
- EXEC2: wait_req ? stay : FETCH.
- HALT: stay until `start`, then FETCH. The STP fetch does not advance R0, so resuming re-fetches STP unless R0 was reloaded externally.
- Retirement: leaving EXEC1 to FETCH/HALT/PAUSE, or leaving EXEC2. instr_count increments by 1 on retirement.
- cycle_count increments every cycle in FETCH, EXEC1, EXEC2 or PAUSE, including stalled cycles.
- Counters wrap from 2^CNT_W-1 to 0. When clr_cnt and an increment coincide, the clear wins (result 0).
- Priorities: rst > wait_req > stp > E2. `start` is ignored outside IDLE/HALT. wait_req is ignored in IDLE/HALT/PAUSE.

## Timing
- Moore outputs decoded from the state register. Exactly one of FETCH/EXEC1/EXEC2/halted is high, or none in IDLE/PAUSE.
- Inputs are sampled on the edge that ends the current phase. The new phase is visible the cycle after.
- Unstalled instruction: 2 cycles (FETCH, EXEC1), or 3 cycles with E2. Each wait_req cycle adds 1.
- With AUTO_START=1, FETCH is first high on the 2nd cycle after rst deasserts (1 cycle in IDLE).
- rst mid-instruction returns to IDLE at the next edge. The aborted instruction is not counted.

## Configuration
- SEQ_STEP_EN defined:
  - Adds ports `step_mode` (in, 1) and `step_req` (in, 1) and the PAUSE state.
  - With step_mode=1, every retirement that would go to FETCH goes to PAUSE instead.
  - PAUSE -> FETCH on a `step_req` pulse.
  - Clearing step_mode while in PAUSE -> FETCH on the next edge.
  - STP still goes to HALT.
- Undefined: no step ports, no PAUSE state. Behaviour is as if step_mode=0.

## Structure
- Package `cpu_seq_pkg`:
  - state enum typedef `seq_state_t`.
  - default CNT_W constant.
  - phase one-hot encoding constants.
- One sub-module `seq_counter`: CNT_W-wide wrapping counter with `en` and synchronous `clr`, clear has priority. Instantiated twice.

## Test plan
- AUTO_START=1, rst released, stream of 3 single-exec instructions (E2=0, stp=0) -> phase sequence IDLE,F,E1,F,E1,F,E1; instr_count=3, cycle_count=6.
- E2=1 on the 2nd instruction -> F,E1,E2 appears once; after 3 instructions instr_count=3, cycle_count=7.
- wait_req high for 4 cycles during EXEC1 -> EXEC1 held 5 cycles; instr_count unchanged until wait_req drops; cycle_count +4 relative to the unstalled run.
- stp=1 and E2=1 together in EXEC1 -> HALT entered (not EXEC2), halted=1, instr_count+1, cycle_count frozen; `start` pulse -> FETCH next cycle.
- instr_count forced near 16'hFFFF, retire 2 instructions -> wraps to 16'h0001. clr_cnt coincident with a retirement -> instr_count=0.
- SEQ_STEP_EN, step_mode=1 -> PAUSE after each instruction; 2 step_req pulses -> exactly 2 more instructions retire. rst asserted in PAUSE -> IDLE, counters 0.
